pic_priority_resolver: RTL and testbench

Upstream stage of the 8259 control unit. It holds the Interrupt Request Register (IRR), the In-Service Register (ISR) and the rotating priority resolver. It samples the IR0–IR7 request lines, applies the mask, and raises INTERNAL_INT together with the winning IR_NUM. It tracks the two-pulse INTA_ sequence to move the winner from IRR into ISR, and clears ISR on EOI or AEOI.

---
 rtl/pic_priority_resolver.sv | 179 +++++++++++++++++
 tb/tb_pic_priority_resolver.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/pic_priority_resolver.sv
// pic_priority_resolver: IRR/ISR bookkeeping and rotating priority resolver
// for the 8259 control path. Request and acknowledge lines are asynchronous
// and are synchronized before any edge detection.
module pic_priority_resolver #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       CLK,
   input  logic       RESET_,
   input  logic [7:0] IR,
   input  logic       LEVEL,
   input  logic [7:0] interrupt_mask,
   input  logic       INTA_,
   input  logic       AEOI,
   input  logic       R,
   input  logic       EOI_PULSE,
   input  logic       SEOI,
   input  logic [2:0] EOI_LEVEL,
   output logic       INTERNAL_INT,
   output logic [2:0] IR_NUM,
   output logic [7:0] IRR,
   output logic [7:0] ISR
);

   typedef enum logic {S_IDLE, S_ACK2} state_t;

   logic [SYNC_STAGES-1:0][7:0] r_ir_sync;
   logic [7:0]                  r_ir_prev;
   logic [SYNC_STAGES-1:0]      r_inta_sync;
   logic                        r_inta_prev;

   state_t     r_state, w_state_nxt;
   logic [7:0] r_irr, r_isr;
   logic [2:0] r_low, r_num;
   logic       r_int;

   logic [7:0] w_ir_s, w_ir_rise, w_cand;
   logic       w_inta_fall;
   logic [3:0] w_win, w_isr_top;
   logic [2:0] w_win_rank, w_isr_rank;
   logic       w_qual;

   logic       w_int_nxt;
   logic [2:0] w_num_nxt;
   logic [7:0] w_isr_set, w_ack_clr, w_aeoi_clr, w_eoi_clr;
   logic       w_aeoi_rot, w_eoi_rot;
   logic [2:0] w_eoi_num;

   // Lowest-rank set bit of v, scanning from the bit just above LOW.
   // Returns {found, bit number}.
   function automatic logic [3:0] f_pick(input logic [7:0] v, input logic [2:0] low);
      logic [3:0] res;
      logic [2:0] idx;
      res = '0;
      for (int k = 7; k >= 0; k--) begin
         idx = 3'(k) + low + 3'd1;
         if (v[idx]) res = {1'b1, idx};
      end
      return res;
   endfunction

   // Synchronizer chains plus one history flop each for edge detection
   always_ff @(posedge CLK or negedge RESET_) begin
      if (!RESET_) begin
         r_ir_sync   <= '0;
         r_ir_prev   <= '0;
         r_inta_sync <= '1;
         r_inta_prev <= 1'b1;
      end else begin
         r_ir_sync[0]   <= IR;
         r_inta_sync[0] <= INTA_;
         for (int s = 1; s < SYNC_STAGES; s++) begin
            r_ir_sync[s]   <= r_ir_sync[s-1];
            r_inta_sync[s] <= r_inta_sync[s-1];
         end
         r_ir_prev   <= r_ir_sync[SYNC_STAGES-1];
         r_inta_prev <= r_inta_sync[SYNC_STAGES-1];
      end
   end

   assign w_ir_s      = r_ir_sync[SYNC_STAGES-1];
   assign w_ir_rise   = w_ir_s & ~r_ir_prev;
   assign w_inta_fall = r_inta_prev & ~r_inta_sync[SYNC_STAGES-1];

   // A winner must strictly outrank everything already in service
   assign w_cand     = r_irr & ~interrupt_mask & ~r_isr;
   assign w_win      = f_pick(w_cand, r_low);
   assign w_isr_top  = f_pick(r_isr, r_low);
   assign w_win_rank = w_win[2:0] - r_low - 3'd1;
   assign w_isr_rank = w_isr_top[2:0] - r_low - 3'd1;
   assign w_qual     = w_win[3] && (!w_isr_top[3] || (w_win_rank < w_isr_rank));

   // Acknowledge state register
   always_ff @(posedge CLK or negedge RESET_) begin
      if (!RESET_) r_state <= S_IDLE;
      else         r_state <= w_state_nxt;
   end

   // Each synced INTA fall advances the two-pulse acknowledge
   always_comb begin
      w_state_nxt = r_state;
      if (w_inta_fall) w_state_nxt = (r_state == S_IDLE) ? S_ACK2 : S_IDLE;
   end

   // Acknowledge-driven outputs and ISR/IRR set/clear vectors
   always_comb begin
      w_int_nxt  = r_int;
      w_num_nxt  = r_num;
      w_isr_set  = '0;
      w_ack_clr  = '0;
      w_aeoi_clr = '0;
      w_aeoi_rot = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_int_nxt = w_qual;
            if (w_win[3]) w_num_nxt = w_win[2:0];
            if (w_inta_fall) begin
               w_int_nxt = 1'b0;
               if (w_qual) begin
                  w_num_nxt             = w_win[2:0];
                  w_isr_set[w_win[2:0]] = 1'b1;
                  w_ack_clr[w_win[2:0]] = 1'b1;
               end else begin
                  // nothing to service: report the spurious vector
                  w_num_nxt = 3'd7;
               end
            end
         end
         S_ACK2: begin
            w_int_nxt = 1'b0;
            if (w_inta_fall && AEOI) begin
               w_aeoi_clr[r_num] = 1'b1;
               w_aeoi_rot        = R;
            end
         end
         default: ;
      endcase
   end

   // EOI decode, judged against the ISR before this cycle's updates
   always_comb begin
      w_eoi_clr = '0;
      w_eoi_rot = 1'b0;
      w_eoi_num = EOI_LEVEL;
      if (EOI_PULSE) begin
         if (SEOI) begin
            w_eoi_clr[EOI_LEVEL] = 1'b1;
            w_eoi_rot            = R && r_isr[EOI_LEVEL];
         end else if (w_isr_top[3]) begin
            w_eoi_num               = w_isr_top[2:0];
            w_eoi_clr[w_isr_top[2:0]] = 1'b1;
            w_eoi_rot               = R;
         end
      end
   end

   // Register update: sets beat clears, AEOI rotation beats EOI rotation
   always_ff @(posedge CLK or negedge RESET_) begin
      if (!RESET_) begin
         r_irr <= '0;
         r_isr <= '0;
         r_low <= 3'd7;
         r_num <= '0;
         r_int <= 1'b0;
      end else begin
         r_isr <= (r_isr & ~w_eoi_clr & ~w_aeoi_clr) | w_isr_set;
         r_irr <= LEVEL ? w_ir_s : ((r_irr & ~w_ack_clr) | w_ir_rise);
         r_num <= w_num_nxt;
         r_int <= w_int_nxt;
         if (w_aeoi_rot)     r_low <= r_num;
         else if (w_eoi_rot) r_low <= w_eoi_num;
      end
   end

   assign INTERNAL_INT = r_int;
   assign IR_NUM       = r_num;
   assign IRR          = r_irr;
   assign ISR          = r_isr;

endmodule

// File: tb/tb_pic_priority_resolver.sv
// Directed bench for pic_priority_resolver with hand-computed expectations.
module tb_pic_priority_resolver;

   logic       CLK = 1'b0;
   logic       RESET_ = 1'b1;
   logic [7:0] IR = '0;
   logic       LEVEL = 1'b0;
   logic [7:0] interrupt_mask = '0;
   logic       INTA_ = 1'b1;
   logic       AEOI = 1'b0;
   logic       R = 1'b0;
   logic       EOI_PULSE = 1'b0;
   logic       SEOI = 1'b0;
   logic [2:0] EOI_LEVEL = '0;
   logic       INTERNAL_INT;
   logic [2:0] IR_NUM;
   logic [7:0] IRR, ISR;

   int n_cmp = 0;
   int n_err = 0;

   always #5 CLK = ~CLK;

   pic_priority_resolver #(.SYNC_STAGES(2)) dut (
      .CLK(CLK), .RESET_(RESET_), .IR(IR), .LEVEL(LEVEL),
      .interrupt_mask(interrupt_mask), .INTA_(INTA_), .AEOI(AEOI), .R(R),
      .EOI_PULSE(EOI_PULSE), .SEOI(SEOI), .EOI_LEVEL(EOI_LEVEL),
      .INTERNAL_INT(INTERNAL_INT), .IR_NUM(IR_NUM), .IRR(IRR), .ISR(ISR)
   );

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic set_ir(input logic [7:0] v);
      @(negedge CLK);
      IR = v;
   endtask

   // one full INTA_ pulse: low long enough to pass the synchronizer, then high
   task automatic inta();
      @(negedge CLK);
      INTA_ = 1'b0;
      cyc(4);
      @(negedge CLK);
      INTA_ = 1'b1;
      cyc(4);
   endtask

   task automatic eoi(input logic spec, input logic [2:0] lvl);
      @(negedge CLK);
      EOI_PULSE = 1'b1;
      SEOI      = spec;
      EOI_LEVEL = lvl;
      @(negedge CLK);
      EOI_PULSE = 1'b0;
      SEOI      = 1'b0;
      cyc(2);
   endtask

   initial begin
      // reset state
      #2 RESET_ = 1'b0;
      #1;
      chk("rst_int", INTERNAL_INT, 0);
      chk("rst_num", IR_NUM, 0);
      chk("rst_irr", IRR, 8'h00);
      chk("rst_isr", ISR, 8'h00);
      cyc(3);
      @(negedge CLK);
      RESET_ = 1'b1;
      cyc(3);

      // edge mode, IR3 pulse: latency exactly 4 clocks
      @(negedge CLK);
      IR = 8'h08;
      cyc(3);
      chk("lat3_int", INTERNAL_INT, 0);
      cyc(1);
      chk("lat4_int", INTERNAL_INT, 1);
      chk("lat4_num", IR_NUM, 3);
      set_ir(8'h00);
      cyc(2);
      inta();
      chk("ack1_isr", ISR, 8'h08);
      chk("ack1_irr", IRR, 8'h00);
      chk("ack1_int", INTERNAL_INT, 0);
      inta();
      chk("ack2_isr", ISR, 8'h08);
      chk("ack2_int", INTERNAL_INT, 0);

      // nesting: IR5 blocked by IR3 in service, IR1 gets through
      set_ir(8'h20);
      cyc(6);
      chk("nest5_int", INTERNAL_INT, 0);
      chk("nest5_irr", IRR, 8'h20);
      set_ir(8'h02);
      cyc(6);
      chk("nest1_int", INTERNAL_INT, 1);
      chk("nest1_num", IR_NUM, 1);
      set_ir(8'h00);
      inta();
      inta();
      chk("nest_isr", ISR, 8'h0A);
      chk("nest_irr", IRR, 8'h20);
      chk("nest_int", INTERNAL_INT, 0);

      // EOI: non-specific clears IR1, specific clears IR3, then IR5 fires
      eoi(1'b0, 3'd0);
      chk("nseoi_isr", ISR, 8'h08);
      chk("nseoi_int", INTERNAL_INT, 0);
      eoi(1'b1, 3'd3);
      chk("seoi_isr", ISR, 8'h00);
      chk("seoi_int", INTERNAL_INT, 1);
      chk("seoi_num", IR_NUM, 5);
      AEOI = 1'b1;
      inta();
      chk("aeoi1_isr", ISR, 8'h20);
      inta();
      chk("aeoi2_isr", ISR, 8'h00);
      chk("aeoi2_irr", IRR, 8'h00);
      R = 1'b1;
      eoi(1'b0, 3'd0);
      chk("eoi0_isr", ISR, 8'h00);

      // rotation with AEOI
      set_ir(8'h44);
      cyc(6);
      chk("rot_int", INTERNAL_INT, 1);
      chk("rot_num2", IR_NUM, 2);
      set_ir(8'h00);
      inta();
      chk("rot1_isr", ISR, 8'h04);
      chk("rot1_irr", IRR, 8'h40);
      inta();
      chk("rot2_isr", ISR, 8'h00);
      chk("rot2_int", INTERNAL_INT, 1);
      chk("rot_num6", IR_NUM, 6);
      // LOW=2: IR3 outranks both IR6 and IR0
      set_ir(8'h09);
      cyc(6);
      chk("rot_num3", IR_NUM, 3);
      set_ir(8'h00);
      inta();
      inta();
      chk("rot3_irr", IRR, 8'h41);
      // LOW=3: IR6 (rank 2) ahead of IR0 (rank 4)
      chk("rot_num6b", IR_NUM, 6);
      inta();
      inta();
      // LOW=6: IR0 now top
      chk("rot_num0", IR_NUM, 0);
      chk("rot_int0", INTERNAL_INT, 1);
      inta();
      inta();
      chk("rot_end_irr", IRR, 8'h00);
      chk("rot_end_isr", ISR, 8'h00);
      chk("rot_end_int", INTERNAL_INT, 0);

      // level mode
      R = 1'b0;
      AEOI = 1'b0;
      @(negedge CLK);
      LEVEL = 1'b1;
      set_ir(8'h10);
      cyc(5);
      chk("lvl_int", INTERNAL_INT, 1);
      chk("lvl_num", IR_NUM, 4);
      inta();
      inta();
      chk("lvl_irr", IRR, 8'h10);
      chk("lvl_isr", ISR, 8'h10);
      chk("lvl_int0", INTERNAL_INT, 0);
      eoi(1'b0, 3'd0);
      chk("lvl_eoi_isr", ISR, 8'h00);
      chk("lvl_eoi_int", INTERNAL_INT, 1);
      chk("lvl_eoi_num", IR_NUM, 4);
      @(negedge CLK);
      interrupt_mask = 8'h10;
      cyc(1);
      chk("mask_int", INTERNAL_INT, 0);
      chk("mask_irr", IRR, 8'h10);
      @(negedge CLK);
      interrupt_mask = 8'h00;
      cyc(2);
      chk("unmask_int", INTERNAL_INT, 1);

      // reset while waiting for the second INTA
      @(negedge CLK);
      INTA_ = 1'b0;
      cyc(4);
      chk("pre_rst_isr", ISR, 8'h10);
      @(negedge CLK);
      INTA_ = 1'b1;
      IR = 8'h00;
      LEVEL = 1'b0;
      cyc(1);
      @(negedge CLK);
      RESET_ = 1'b0;
      #1;
      chk("mrst_int", INTERNAL_INT, 0);
      chk("mrst_num", IR_NUM, 0);
      chk("mrst_irr", IRR, 8'h00);
      chk("mrst_isr", ISR, 8'h00);
      cyc(2);
      @(negedge CLK);
      RESET_ = 1'b1;
      cyc(4);
      // fresh sequence with nothing pending: spurious IR7
      inta();
      chk("spur_isr", ISR, 8'h00);
      chk("spur_num", IR_NUM, 7);
      chk("spur_int", INTERNAL_INT, 0);
      inta();
      chk("spur2_isr", ISR, 8'h00);
      chk("spur2_num", IR_NUM, 7);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
